// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the RV32I memory-access stage.
package mem_stage_pkg;

  typedef logic [31:0] data_t;
  typedef logic [4:0]  reg_addr_t;

  // Value driven on the write-data bus when no store is being presented.
  localparam data_t DATA_UNKNOWN = 32'h0000_0000;

  typedef enum logic [3:0] {
    MEM_NONE,
    LB,
    LH,
    LW,
    LBU,
    LHU,
    SB,
    SH,
    SW
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } mem_state_t;

  function automatic logic is_load(input mem_op_t op);
    return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
  endfunction

  function automatic logic is_store(input mem_op_t op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  // Halfwords need an even address, words need a 4-byte aligned address.
  function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] a);
    logic half_op;
    logic word_op;
    half_op = (op == LH) || (op == LHU) || (op == SH);
    word_op = (op == LW) || (op == SW);
    return (half_op && a[0]) || (word_op && (a != 2'b00));
  endfunction

  // Byte enables for a store at the given byte offset within the word.
  function automatic logic [3:0] store_strobe(input mem_op_t op, input logic [1:0] a);
    logic [3:0] strb;
    case (op)
      SB:      strb = 4'b0001 << a;
      SH:      strb = 4'b0011 << a;
      SW:      strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

  // Store data replicated across lanes so the strobes select the right bytes.
  function automatic data_t store_lanes(input mem_op_t op, input data_t d);
    data_t w;
    case (op)
      SB:      w = {4{d[7:0]}};
      SH:      w = {2{d[15:0]}};
      SW:      w = d;
      default: w = DATA_UNKNOWN;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Selects the addressed byte/halfword of a load word and sign/zero extends it.
module load_extend
  import mem_stage_pkg::*;
(
  input  mem_op_t    mem_op_i,
  input  logic [1:0] addr_lo_i,
  input  data_t      rdata_i,
  output data_t      data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane extraction followed by extension chosen by the load flavour.
  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    data_o   = rdata_i;
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (mem_op_i)
      LB:      data_o = {{24{byte_sel[7]}}, byte_sel};
      LBU:     data_o = {24'h000000, byte_sel};
      LH:      data_o = {{16{half_sel[15]}}, half_sel};
      LHU:     data_o = {16'h0000, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores on a req/gnt/rvalid port,
// aligns and extends load data, and registers the MEM/WB boundary.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  mem_op_t           mem_op_i,
  input  logic [XLEN-1:0]   alu_result_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  reg_addr_t         rd_i,
  input  logic              wb_en_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_wstrb_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic              valid_o,
  output reg_addr_t         rd_o,
  output logic              wb_en_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic              misalign_o
);

  mem_state_t        state_q, state_d;
  mem_op_t           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        wstrb_q, wstrb_d;
  data_t             wdata_q, wdata_d;
  reg_addr_t         rd_hold_q, rd_hold_d;
  logic              wb_en_hold_q, wb_en_hold_d;
  logic              kill_q, kill_d;

  logic              valid_q, valid_d;
  reg_addr_t         rd_out_q, rd_out_d;
  logic              wb_en_q, wb_en_d;
  data_t             wb_data_q, wb_data_d;
  logic              misalign_q, misalign_d;

  logic              live_op;
  logic              accept_mem;
  logic              op_misaligned;
  logic              discard;
  data_t             load_data;

  load_extend u_load_extend (
    .mem_op_i  (op_q),
    .addr_lo_i (addr_q[1:0]),
    .rdata_i   (dmem_rdata_i),
    .data_o    (load_data)
  );

  // Decode of the incoming op: is it live, misaligned, or an accepted memory access.
  always_comb begin
    live_op       = valid_i && !flush_i;
    op_misaligned = is_misaligned(mem_op_i, alu_result_i[1:0]);
    accept_mem    = (state_q == IDLE) && live_op && (mem_op_i != MEM_NONE) && !op_misaligned;
    discard       = kill_q || flush_i;
  end

  // Next-state and MEM/WB result computation; outputs pulse for one cycle by default.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    rd_hold_d    = rd_hold_q;
    wb_en_hold_d = wb_en_hold_q;
    kill_d       = kill_q;
    valid_d      = 1'b0;
    rd_out_d     = rd_out_q;
    wb_en_d      = 1'b0;
    wb_data_d    = wb_data_q;
    misalign_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (live_op) begin
          if (mem_op_i == MEM_NONE) begin
            valid_d   = 1'b1;
            rd_out_d  = rd_i;
            wb_en_d   = wb_en_i;
            wb_data_d = alu_result_i;
          end else if (op_misaligned) begin
            valid_d    = 1'b1;
            rd_out_d   = rd_i;
            misalign_d = 1'b1;
          end else begin
            state_d      = REQ;
            op_d         = mem_op_i;
            addr_d       = alu_result_i[ADDR_W-1:0];
            wstrb_d      = store_strobe(mem_op_i, alu_result_i[1:0]);
            wdata_d      = store_lanes(mem_op_i, store_data_i);
            rd_hold_d    = rd_i;
            wb_en_hold_d = wb_en_i;
            kill_d       = 1'b0;
          end
        end
      end
      REQ: begin
        if (dmem_gnt_i) begin
          if (is_store(op_q)) begin
            state_d = IDLE;
            if (!discard) begin
              valid_d  = 1'b1;
              rd_out_d = rd_hold_q;
            end
          end else begin
            state_d = WAIT;
            kill_d  = discard;
          end
        end else if (flush_i) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          state_d = IDLE;
          if (!discard) begin
            valid_d   = 1'b1;
            rd_out_d  = rd_hold_q;
            wb_en_d   = wb_en_hold_q;
            wb_data_d = load_data;
          end
        end else begin
          kill_d = discard;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      op_q         <= MEM_NONE;
      addr_q       <= '0;
      wstrb_q      <= 4'h0;
      wdata_q      <= DATA_UNKNOWN;
      rd_hold_q    <= '0;
      wb_en_hold_q <= 1'b0;
      kill_q       <= 1'b0;
      valid_q      <= 1'b0;
      rd_out_q     <= '0;
      wb_en_q      <= 1'b0;
      wb_data_q    <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      rd_hold_q    <= rd_hold_d;
      wb_en_hold_q <= wb_en_hold_d;
      kill_q       <= kill_d;
      valid_q      <= valid_d;
      rd_out_q     <= rd_out_d;
      wb_en_q      <= wb_en_d;
      wb_data_q    <= wb_data_d;
      misalign_q   <= misalign_d;
    end
  end

  // Memory port driven from the holding registers so it stays stable until gnt.
  always_comb begin
    dmem_req_o   = (state_q == REQ);
    dmem_we_o    = is_store(op_q);
    dmem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
    dmem_wstrb_o = wstrb_q;
    dmem_wdata_o = wdata_q;
    stall_o      = (state_q != IDLE) || accept_mem;
    valid_o      = valid_q;
    rd_o         = rd_out_q;
    wb_en_o      = wb_en_q;
    wb_data_o    = wb_data_q;
    misalign_o   = misalign_q;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table plus flush/reset sequences.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk_i;
  logic        rst_i;
  logic        valid_i;
  mem_op_t     mem_op_i;
  logic [31:0] alu_result_i;
  logic [31:0] store_data_i;
  logic [4:0]  rd_i;
  logic        wb_en_i;
  logic        flush_i;
  logic        stall_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_wstrb_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        valid_o;
  logic [4:0]  rd_o;
  logic        wb_en_o;
  logic [31:0] wb_data_o;
  logic        misalign_o;

  int passed = 0;
  int total  = 0;

  typedef struct {
    mem_op_t     op;
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic        wb_en;
    int          gnt_wait;
    int          rv_wait;
    logic [31:0] rdata;
    logic        exp_acc;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic        exp_mis;
    logic        exp_wb_en;
    logic [31:0] exp_wb_data;
  } vec_t;

  typedef struct {
    logic        mis;
    logic        wb_en;
    logic [4:0]  rd;
    logic [31:0] data;
  } sb_item_t;

  sb_item_t sb_q[$];
  vec_t     vecs[15];

  mem_stage #(.ADDR_W(32), .XLEN(32)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .valid_i       (valid_i),
    .mem_op_i      (mem_op_i),
    .alu_result_i  (alu_result_i),
    .store_data_i  (store_data_i),
    .rd_i          (rd_i),
    .wb_en_i       (wb_en_i),
    .flush_i       (flush_i),
    .stall_o       (stall_o),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_wstrb_o  (dmem_wstrb_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .valid_o       (valid_o),
    .rd_o          (rd_o),
    .wb_en_o       (wb_en_o),
    .wb_data_o     (wb_data_o),
    .misalign_o    (misalign_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Retirement monitor: every valid_o pulse must match the oldest expected result.
  always @(negedge clk_i) begin
    if (valid_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_valid", 32'd1, 32'd0);
      end else begin
        sb_item_t it;
        it = sb_q.pop_front();
        checkOutput("sb_misalign", 32'(misalign_o), 32'(it.mis));
        checkOutput("sb_wb_en", 32'(wb_en_o), 32'(it.wb_en));
        if (it.wb_en) begin
          checkOutput("sb_rd", 32'(rd_o), 32'(it.rd));
          checkOutput("sb_wb_data", wb_data_o, it.data);
        end
      end
    end
  end

  task automatic idleInputs();
    valid_i       = 1'b0;
    mem_op_i      = MEM_NONE;
    alu_result_i  = 32'h0;
    store_data_i  = 32'h0;
    rd_i          = 5'd0;
    wb_en_i       = 1'b0;
    flush_i       = 1'b0;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'h0;
  endtask

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one op from the table, play the memory side, and check the port each cycle.
  task automatic applyStimulus(input vec_t v);
    int       stall_cnt;
    sb_item_t it;
    stall_cnt    = 0;
    valid_i      = 1'b1;
    mem_op_i     = v.op;
    alu_result_i = v.alu;
    store_data_i = v.sdata;
    rd_i         = v.rd;
    wb_en_i      = v.wb_en;
    #1;
    checkOutput("issue_stall", 32'(stall_o), 32'(v.exp_acc));
    checkOutput("issue_req", 32'(dmem_req_o), 32'd0);
    if (stall_o) stall_cnt++;
    it.mis   = v.exp_mis;
    it.wb_en = v.exp_wb_en;
    it.rd    = v.rd;
    it.data  = v.exp_wb_data;
    sb_q.push_back(it);
    nextCycle();
    valid_i  = 1'b0;
    mem_op_i = MEM_NONE;
    if (v.exp_acc) begin
      for (int i = 0; i <= v.gnt_wait; i++) begin
        dmem_gnt_i = (i == v.gnt_wait);
        #1;
        checkOutput("req_high", 32'(dmem_req_o), 32'd1);
        checkOutput("req_addr", dmem_addr_o, v.exp_addr);
        checkOutput("req_we", 32'(dmem_we_o), 32'(is_store(v.op)));
        if (is_store(v.op)) begin
          checkOutput("req_wstrb", 32'(dmem_wstrb_o), 32'(v.exp_wstrb));
          checkOutput("req_wdata", dmem_wdata_o, v.exp_wdata);
        end
        if (stall_o) stall_cnt++;
        nextCycle();
        dmem_gnt_i = 1'b0;
      end
      if (is_load(v.op)) begin
        for (int i = 1; i <= v.rv_wait; i++) begin
          if (i == v.rv_wait) begin
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = v.rdata;
          end
          #1;
          checkOutput("wait_req_low", 32'(dmem_req_o), 32'd0);
          if (stall_o) stall_cnt++;
          nextCycle();
          dmem_rvalid_i = 1'b0;
          dmem_rdata_i  = 32'h0;
        end
      end
      checkOutput("stall_cycles", 32'(stall_cnt),
                  32'(1 + v.gnt_wait + 1 + (is_load(v.op) ? v.rv_wait : 0)));
    end
    checkOutput("retire_valid", 32'(valid_o), 32'd1);
    checkOutput("retire_stall", 32'(stall_o), 32'd0);
    checkOutput("retire_req", 32'(dmem_req_o), 32'd0);
  endtask

  // Issue a load/store without queuing a result; used by the flush/reset sequences.
  task automatic issueNoRetire(input mem_op_t op, input logic [31:0] addr, input logic [4:0] rd);
    valid_i      = 1'b1;
    mem_op_i     = op;
    alu_result_i = addr;
    store_data_i = 32'h1357_9BDF;
    rd_i         = rd;
    wb_en_i      = is_load(op);
    nextCycle();
    idleInputs();
  endtask

  initial begin
    idleInputs();
    rst_i = 1'b1;
    vecs[0]  = '{MEM_NONE, 32'h0000_1234, 32'h0, 5'd5,  1'b1, 0, 0, 32'h0,         1'b0, 32'h0,   4'h0,    32'h0,         1'b0, 1'b1, 32'h0000_1234};
    vecs[1]  = '{SB,       32'h0000_0103, 32'hAB, 5'd0, 1'b0, 2, 0, 32'h0,         1'b1, 32'h100, 4'b1000, 32'hABAB_ABAB, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{LB,       32'h0000_0202, 32'h0, 5'd3,  1'b1, 0, 2, 32'h0080_0000, 1'b1, 32'h200, 4'h0,    32'h0,         1'b0, 1'b1, 32'hFFFF_FF80};
    vecs[3]  = '{LBU,      32'h0000_0202, 32'h0, 5'd4,  1'b1, 0, 2, 32'h0080_0000, 1'b1, 32'h200, 4'h0,    32'h0,         1'b0, 1'b1, 32'h0000_0080};
    vecs[4]  = '{LW,       32'h0000_0006, 32'h0, 5'd6,  1'b1, 0, 0, 32'h0,         1'b0, 32'h0,   4'h0,    32'h0,         1'b1, 1'b0, 32'h0};
    vecs[5]  = '{SH,       32'h0000_0102, 32'h1234_ABCD, 5'd0, 1'b0, 1, 0, 32'h0,  1'b1, 32'h100, 4'b1100, 32'hABCD_ABCD, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{SW,       32'h0000_0200, 32'hDEAD_BEEF, 5'd0, 1'b0, 0, 0, 32'h0,  1'b1, 32'h200, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{LH,       32'h0000_0202, 32'h0, 5'd8,  1'b1, 1, 1, 32'h8001_0000, 1'b1, 32'h200, 4'h0,    32'h0,         1'b0, 1'b1, 32'hFFFF_8001};
    vecs[8]  = '{LHU,      32'h0000_020A, 32'h0, 5'd9,  1'b1, 0, 3, 32'h8001_7FFF, 1'b1, 32'h208, 4'h0,    32'h0,         1'b0, 1'b1, 32'h0000_8001};
    vecs[9]  = '{LW,       32'h0000_0010, 32'h0, 5'd10, 1'b1, 0, 1, 32'hCAFE_F00D, 1'b1, 32'h010, 4'h0,    32'h0,         1'b0, 1'b1, 32'hCAFE_F00D};
    vecs[10] = '{LB,       32'h0000_0201, 32'h0, 5'd11, 1'b1, 0, 1, 32'h1122_3344, 1'b1, 32'h200, 4'h0,    32'h0,         1'b0, 1'b1, 32'h0000_0033};
    vecs[11] = '{SH,       32'h0000_0101, 32'h5555, 5'd0, 1'b0, 0, 0, 32'h0,       1'b0, 32'h0,   4'h0,    32'h0,         1'b1, 1'b0, 32'h0};
    vecs[12] = '{LHU,      32'h0000_0003, 32'h0, 5'd12, 1'b1, 0, 0, 32'h0,         1'b0, 32'h0,   4'h0,    32'h0,         1'b1, 1'b0, 32'h0};
    vecs[13] = '{MEM_NONE, 32'hFFFF_FFFF, 32'h0, 5'd31, 1'b0, 0, 0, 32'h0,         1'b0, 32'h0,   4'h0,    32'h0,         1'b0, 1'b0, 32'h0};
    vecs[14] = '{SB,       32'h0000_0000, 32'h5A, 5'd0, 1'b0, 0, 0, 32'h0,         1'b1, 32'h000, 4'b0001, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'h0};

    repeat (3) nextCycle();
    checkOutput("rst_valid", 32'(valid_o), 32'd0);
    checkOutput("rst_wb_en", 32'(wb_en_o), 32'd0);
    checkOutput("rst_misalign", 32'(misalign_o), 32'd0);
    checkOutput("rst_req", 32'(dmem_req_o), 32'd0);
    checkOutput("rst_stall", 32'(stall_o), 32'd0);
    checkOutput("rst_rd", 32'(rd_o), 32'd0);
    checkOutput("rst_wb_data", wb_data_o, 32'd0);
    rst_i = 1'b0;
    nextCycle();

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
    end
    nextCycle();

    $display("[TB] sequence: flush load in WAIT");
    issueNoRetire(LW, 32'h0000_0040, 5'd7);
    dmem_gnt_i = 1'b1;
    nextCycle();
    dmem_gnt_i = 1'b0;
    flush_i    = 1'b1;
    #1;
    checkOutput("flushw_stall_wait", 32'(stall_o), 32'd1);
    nextCycle();
    flush_i       = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h7777_7777;
    #1;
    checkOutput("flushw_stall_rvalid", 32'(stall_o), 32'd1);
    nextCycle();
    idleInputs();
    checkOutput("flushw_valid", 32'(valid_o), 32'd0);
    checkOutput("flushw_stall_after", 32'(stall_o), 32'd0);
    nextCycle();

    $display("[TB] sequence: flush store in REQ before gnt");
    issueNoRetire(SW, 32'h0000_0300, 5'd0);
    flush_i = 1'b1;
    #1;
    checkOutput("flushr_req_before", 32'(dmem_req_o), 32'd1);
    nextCycle();
    flush_i = 1'b0;
    #1;
    checkOutput("flushr_req_after", 32'(dmem_req_o), 32'd0);
    checkOutput("flushr_stall_after", 32'(stall_o), 32'd0);
    checkOutput("flushr_valid", 32'(valid_o), 32'd0);
    nextCycle();

    $display("[TB] sequence: reset in WAIT with late rvalid");
    issueNoRetire(LW, 32'h0000_0080, 5'd9);
    dmem_gnt_i = 1'b1;
    nextCycle();
    dmem_gnt_i = 1'b0;
    rst_i      = 1'b1;
    nextCycle();
    rst_i         = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h1234_5678;
    #1;
    checkOutput("rstw_stall", 32'(stall_o), 32'd0);
    checkOutput("rstw_req", 32'(dmem_req_o), 32'd0);
    checkOutput("rstw_valid", 32'(valid_o), 32'd0);
    checkOutput("rstw_rd", 32'(rd_o), 32'd0);
    checkOutput("rstw_wb_data", wb_data_o, 32'd0);
    checkOutput("rstw_wb_en", 32'(wb_en_o), 32'd0);
    checkOutput("rstw_misalign", 32'(misalign_o), 32'd0);
    nextCycle();
    idleInputs();
    checkOutput("rstw_late_rvalid_valid", 32'(valid_o), 32'd0);
    checkOutput("rstw_late_rvalid_stall", 32'(stall_o), 32'd0);
    applyStimulus(vecs[0]);
    nextCycle();
    nextCycle();

    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV32I pipeline, directly downstream of the execute-stage ALU.
- Consumes the ALU result as either a load/store effective address or a pass-through writeback value.
- Drives a req/gnt/rvalid data-memory port, performs byte-lane alignment and load sign/zero extension, and registers the result into the MEM/WB boundary.
- Stalls the upstream pipeline while a memory transaction is outstanding.

Parameters:
- ADDR_W, 32, byte-address width presented to data memory.
- XLEN, 32, data width; fixed at 32 for RV32I.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- valid_i  in  1  EX/MEM slot holds a live instruction.
- mem_op_i  in  mem_op_t  MEM_NONE, LB, LH, LW, LBU, LHU, SB, SH, SW.
- alu_result_i  in  32  ALU output: address for loads/stores, writeback data otherwise.
- store_data_i  in  32  rs2 value, already forwarded.
- rd_i  in  5  destination register.
- wb_en_i  in  1  instruction writes rd.
- flush_i  in  1  kill the instruction currently in this stage.
- stall_o  out  1  hold EX/MEM and all earlier stages.
- dmem_req_o  out  1  memory request.
- dmem_we_o  out  1  1 = store.
- dmem_addr_o  out  32  word-aligned address, addr[1:0] = 0.
- dmem_wstrb_o  out  4  byte enables.
- dmem_wdata_o  out  32  lane-shifted store data.
- dmem_gnt_i  in  1  request accepted this cycle.
- dmem_rvalid_i  in  1  load data valid; arrives 1 or more cycles after gnt.
- dmem_rdata_i  in  32  load word.
- valid_o  out  1  MEM/WB slot valid.
- rd_o  out  5  registered rd.
- wb_en_o  out  1  registered writeback enable.
- wb_data_o  out  32  registered writeback value.
- misalign_o  out  1  registered misaligned-access flag, qualified by valid_o.

Behaviour:
- Reset: state = IDLE; valid_o, wb_en_o, misalign_o, dmem_req_o, stall_o = 0; rd_o = 0; wb_data_o = 0.
- FSM states: IDLE, REQ, WAIT.
- IDLE, no live op (valid_i = 0 or flush_i = 1): next cycle valid_o = 0.
- IDLE, valid_i & MEM_NONE: 1-cycle pass-through. Next cycle valid_o = 1, wb_data_o = alu_result_i, rd_o/wb_en_o registered from inputs.
- IDLE, valid_i & load/store, aligned: capture op, address, data and rd into internal holding registers; go to REQ. stall_o = 1 combinationally from this cycle until completion.
- Misalignment:
  - LH/LHU/SH with addr[0] = 1 is misaligned.
  - LW/SW with addr[1:0] != 0 is misaligned.
  - A misaligned op issues no memory access. Next cycle: valid_o = 1, misalign_o = 1, wb_en_o = 0. No stall.
- REQ state:
  - dmem_req_o = 1; address, we, wstrb and wdata held stable until gnt.
  - On gnt, store: complete. Next cycle valid_o = 1, wb_en_o = 0; return to IDLE.
  - On gnt, load: go to WAIT.
- WAIT state: on rvalid, extract the lane by addr[1:0], extend, then:
  - next cycle valid_o = 1, wb_data_o = extended value, wb_en_o = held wb_en;
  - return to IDLE.
- Store encoding:
  - SB: wstrb = 1 << addr[1:0]; wdata = {4{data[7:0]}}.
  - SH: wstrb = 4'b0011 << addr[1:0]; wdata = {2{data[15:0]}}.
  - SW: wstrb = 4'hF; wdata = data.
- Load extension: LB/LH sign-extend; LBU/LHU zero-extend.
- stall_o: 1 whenever state != IDLE, and in IDLE during the cycle an aligned mem op is accepted. De-asserts in the cycle the result is registered.
- flush_i behaviour:
  - In REQ before gnt: abandon; drop req next cycle; return to IDLE; valid_o = 0.
  - In REQ with gnt in the same cycle, or in WAIT: the transaction must finish. The result is discarded (valid_o = 0) and stall_o is held until rvalid.
- No new op is accepted while state != IDLE.
- rst_i mid-transaction: immediate return to IDLE with all outputs at reset values; a late rvalid arriving in IDLE is ignored.
- valid_o is a single-cycle pulse per retired instruction; there is no back-pressure from WB.

Decomposition:
- Shared package: mem_op_t enum, data_t (32-bit), reg_addr_t (5-bit), DATA_UNKNOWN constant, mem_state_t.
- One combinational sub-module, load_extend: inputs mem_op, addr[1:0], rdata; output extended data_t.

Test Plan:
- MEM_NONE, alu_result_i = 0x0000_1234, rd = 5: one cycle later valid_o = 1, wb_data_o = 0x0000_1234, stall_o never asserted.
- SB, addr 0x103, data 0xAB: dmem_addr_o = 0x100, wstrb = 4'b1000, wdata = 0xABABABAB. gnt delayed 3 cycles: stall_o high for 4 cycles, then valid_o = 1 with wb_en_o = 0.
- LB, addr 0x202, rdata 0x0080_0000, rvalid 2 cycles after gnt: wb_data_o = 0xFFFF_FF80. Same stimulus with LBU gives 0x0000_0080.
- LW at 0x006: no dmem_req_o; next cycle valid_o = 1, misalign_o = 1, wb_en_o = 0.
- LW with flush_i asserted in WAIT: valid_o stays 0 after rvalid, stall_o drops the cycle after rvalid.
- rst_i asserted in WAIT, then rvalid in the following cycle: all outputs 0 and FSM in IDLE; a subsequent MEM_NONE op completes normally.
